// File: rtl/jk_bank_sequencer_if.sv
// rtl/jk_bank_sequencer_if.sv - command and bank-observation bus for jk_bank_sequencer
//
// Purpose: groups the command handshake and the exported JK bank signals.
// Optional feature macro: JK_SEQ_ABORT_EN adds abort (master->slave) and aborted (slave->master).
// Signals:
//   cmd_valid, cmd_op[2:0], cmd_data[WIDTH-1:0], cmd_count[3:0]  master -> slave
//   cmd_ready, j, k, q [WIDTH-1:0], done, wrapped                 slave -> master
interface jk_bank_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [3:0]       cmd_count;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic             done;
  logic             wrapped;
`ifdef JK_SEQ_ABORT_EN
  logic             abort;
  logic             aborted;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count, abort,
    input  cmd_ready, j, k, q, done, wrapped, aborted
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count, abort,
    output cmd_ready, j, k, q, done, wrapped, aborted
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count,
    input  cmd_ready, j, k, q, done, wrapped
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count,
    output cmd_ready, j, k, q, done, wrapped
  );
`endif
endinterface

// File: rtl/jk_bank_sequencer.sv
// rtl/jk_bank_sequencer.sv - command-driven sequencer for a bank of JK flip-flops
//
// Purpose: accepts ops (NOP, CLEAR, LOAD, UP, DOWN, TOGGLE, ROTL) over a valid/ready
// handshake, drives canonical J/K excitation one vector per EXEC cycle into an internal
// JK bank, and pulses done on completion.
// Optional feature macro: JK_SEQ_ABORT_EN (abort input / aborted pulse output).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    jk_bank_sequencer_if.slave (command handshake, j/k/q, done, wrapped)
module jk_bank_sequencer #(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               reset,
  jk_bank_sequencer_if.slave bus
);

  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_UP     = 3'd3;
  localparam logic [2:0] OP_DOWN   = 3'd4;
  localparam logic [2:0] OP_TOGGLE = 3'd5;
  localparam logic [2:0] OP_ROTL   = 3'd6;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [3:0]       cnt_r;     // steps remaining after the current one
  logic [WIDTH-1:0] q_r;
  logic             wrapped_r;

  logic             accept;
  logic             abort_c;
  logic             step_en;
  logic             wrap_c;
  logic             multi_op;  // op whose length comes from cmd_count
  logic             single_op; // op with exactly one step
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j_c;
  logic [WIDTH-1:0] k_c;

`ifdef JK_SEQ_ABORT_EN
  logic aborted_r;
  assign abort_c     = bus.abort;
  assign bus.aborted = (state == S_DONE) && aborted_r;
`else
  assign abort_c = 1'b0;
`endif

  assign accept    = bus.cmd_valid && (state == S_IDLE);
  assign multi_op  = (bus.cmd_op == OP_UP) || (bus.cmd_op == OP_DOWN) || (bus.cmd_op == OP_ROTL);
  assign single_op = (bus.cmd_op == OP_CLEAR) || (bus.cmd_op == OP_LOAD) || (bus.cmd_op == OP_TOGGLE);

  // Step target and excitation; an aborted EXEC cycle drives no excitation.
  always_comb begin
    nxt     = q_r;
    j_c     = '0;
    k_c     = '0;
    wrap_c  = 1'b0;
    step_en = (state == S_EXEC) && !abort_c;
    case (op_r)
      OP_CLEAR:  nxt = '0;
      OP_LOAD:   nxt = data_r;
      OP_UP:     nxt = q_r + ONE;
      OP_DOWN:   nxt = q_r - ONE;
      OP_TOGGLE: nxt = q_r ^ data_r;
      OP_ROTL:   nxt = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
      default:   nxt = q_r;
    endcase
    if (step_en) begin
      j_c    = nxt & ~q_r;
      k_c    = ~nxt & q_r;
      wrap_c = ((op_r == OP_UP) && (&q_r)) || ((op_r == OP_DOWN) && (q_r == '0));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (single_op || (multi_op && (bus.cmd_count != 4'd0))) state_nxt = S_EXEC;
          else                                                      state_nxt = S_DONE;
        end
      end
      S_EXEC: begin
        if (abort_c || (cnt_r == 4'd0)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_r      <= '0;
      data_r    <= '0;
      cnt_r     <= '0;
      q_r       <= '0;
      wrapped_r <= 1'b0;
`ifdef JK_SEQ_ABORT_EN
      aborted_r <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      q_r   <= (j_c & ~q_r) | (~k_c & q_r);
      if (accept) begin
        op_r      <= bus.cmd_op;
        data_r    <= bus.cmd_data;
        // count=0 goes straight to DONE, so the wrapped value of count-1 is never used
        cnt_r     <= multi_op ? (bus.cmd_count - 4'd1) : 4'd0;
        wrapped_r <= 1'b0;
`ifdef JK_SEQ_ABORT_EN
        aborted_r <= 1'b0;
`endif
      end else if (state == S_EXEC) begin
        if (cnt_r != 4'd0) cnt_r <= cnt_r - 4'd1;
        if (wrap_c) wrapped_r <= 1'b1;
`ifdef JK_SEQ_ABORT_EN
        if (abort_c) aborted_r <= 1'b1;
`endif
      end
    end
  end

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.j         = j_c;
  assign bus.k         = k_c;
  assign bus.q         = q_r;
  assign bus.done      = (state == S_DONE);
  assign bus.wrapped   = wrapped_r;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb/tb_jk_bank_sequencer.sv - scoreboard testbench for jk_bank_sequencer
module tb_jk_bank_sequencer;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  jk_bank_sequencer_if #(.WIDTH(W)) bus ();
  jk_bank_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef JK_SEQ_ABORT_EN
  initial bus.abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] q;
    logic       wr;
    int         cyc;
  } exp_t;
  typedef struct {
    logic [3:0] j;
    logic [3:0] k;
  } step_t;

  exp_t  sb[$];
  step_t stq[$];
  bit    mon_en = 1'b0;

  logic [3:0] ref_q = 4'h0;
  int last_acc = 0;
  int last_n = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail(string name, int act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h expected=none at cycle %0d", name, act, cyc);
  endfunction

  // Reference model: plain modular arithmetic over the whole command.
  function automatic int model(input int op, input int data, input int count, input int acc);
    int n;
    int cur;
    int nq;
    bit wr;
    step_t st;
    exp_t e;
    wr  = 1'b0;
    cur = int'(ref_q);
    if (op == 1 || op == 2 || op == 5)      n = 1;
    else if (op == 3 || op == 4 || op == 6) n = count;
    else                                    n = 0;
    for (int i = 0; i < n; i++) begin
      case (op)
        1: nq = 0;
        2: nq = data;
        3: begin if (cur == 15) wr = 1'b1; nq = (cur + 1) % 16; end
        4: begin if (cur == 0) wr = 1'b1; nq = (cur + 15) % 16; end
        5: nq = cur ^ data;
        default: nq = (cur * 2 + cur / 8) % 16;
      endcase
      if (nq != cur) begin
        st.j = 4'(nq & ~cur);
        st.k = 4'(~nq & cur);
        stq.push_back(st);
      end
      cur = nq;
    end
    ref_q = 4'(cur);
    e.q   = ref_q;
    e.wr  = wr;
    e.cyc = acc + n;
    sb.push_back(e);
    return n;
  endfunction

  // Monitor: consumes expected excitation and completions as the DUT shows them.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      chk("jk_overlap", int'(bus.j & bus.k), 0);
      if ((bus.j | bus.k) != 4'h0) begin
        if (stq.size() == 0) fail("unexpected_step", int'({bus.j, bus.k}));
        else begin
          step_t s;
          s = stq.pop_front();
          chk("step_j", int'(bus.j), int'(s.j));
          chk("step_k", int'(bus.k), int'(s.k));
        end
      end
      if (bus.done) begin
        if (sb.size() == 0) fail("unexpected_done", cyc);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_q", int'(bus.q), int'(e.q));
          chk("done_wrapped", int'(bus.wrapped), int'(e.wr));
          chk("done_cycle", cyc, e.cyc);
          chk("steps_left", stq.size(), 0);
        end
      end
    end
  end

  task automatic send(input int op, input int data, input int count, input bit b2b);
    int t;
    int acc;
    t = 0;
    @(negedge clk);
    while (!bus.cmd_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cmd_ready) begin
      fail("ready_timeout", t);
      return;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'(op);
    bus.cmd_data  = 4'(data);
    bus.cmd_count = 4'(count);
    @(posedge clk);
    #1;
    acc = cyc;
    if (b2b) chk("accept_spacing", acc, last_acc + last_n + 2);
    last_n   = model(op, data, count, acc);
    last_acc = acc;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom_range(0, 7));
    bus.cmd_data  = 4'($urandom_range(0, 15));
    bus.cmd_count = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((!bus.cmd_ready || sb.size() != 0) && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cmd_ready || sb.size() != 0) fail("idle_timeout", t);
  endtask

  initial begin
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = 4'h0;
    bus.cmd_count = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_q", int'(bus.q), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_wrapped", int'(bus.wrapped), 0);
    chk("reset_j", int'(bus.j), 0);
    chk("reset_k", int'(bus.k), 0);
    chk("reset_ready", int'(bus.cmd_ready), 1);
    reset  = 1'b0;
    mon_en = 1'b1;

    send(2, 4'hA, 0, 1'b0);
    wait_idle();
    chk("load_q", int'(bus.q), 4'hA);

    send(2, 4'hE, 0, 1'b0);
    send(3, 0, 3, 1'b1);
    wait_idle();
    chk("up_q", int'(bus.q), 4'h1);
    chk("up_wrapped", int'(bus.wrapped), 1);

    send(2, 4'h5, 0, 1'b0);
    send(4, 0, 0, 1'b1);
    wait_idle();
    chk("down0_q", int'(bus.q), 4'h5);
    chk("down0_wrapped", int'(bus.wrapped), 0);

    send(2, 4'h3, 0, 1'b0);
    send(5, 4'h6, 0, 1'b1);
    wait_idle();
    chk("toggle_q", int'(bus.q), 4'h5);
    send(6, 0, 2, 1'b0);
    wait_idle();
    chk("rotl_q", int'(bus.q), 4'h5);

    send(0, 4'hF, 9, 1'b0);
    send(7, 4'hF, 9, 1'b1);
    wait_idle();
    chk("nop_q", int'(bus.q), 4'h5);

    // Reset during a long UP: no done, bank cleared.
    send(2, 4'h2, 0, 1'b0);
    wait_idle();
    mon_en = 1'b0;
    send(3, 0, 8, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_up_q", int'(bus.q), 4'h5);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_reset_q", int'(bus.q), 0);
    chk("mid_reset_done", int'(bus.done), 0);
    chk("mid_reset_ready", int'(bus.cmd_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    stq.delete();
    ref_q  = 4'h0;
    mon_en = 1'b1;
    repeat (12) @(negedge clk);

    send($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15), 1'b0);
    for (int i = 0; i < 60; i++)
      send($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15), 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("final_q", int'(bus.q), int'(ref_q));
    chk("sb_empty", sb.size(), 0);
    chk("steps_empty", stq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
